arith_stage_pipe: RTL
=====================

Name: arith_stage_pipe

Overview:
- Parametrised, handshaked successor of the accelerator's PE arithmetic stage.
- Instantiates NUM_PES 32-bit PE lanes and selects operands (vs1 / replicated scalar / immediate / ripple).
- Adds a registered output with valid/ready flow control.
- Adds a multi-beat reduction engine that carries a running accumulator across beats, so vectors longer than NUM_PES elements reduce correctly.
- Sits between the operand-fetch stage and the writeback stage.

Parameters:
- NUM_PES, 4: number of 32-bit PE lanes; must be ≥2 and a power of two.
- DW, 32*NUM_PES: datapath width (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_last  in  1  last beat of the current vector instruction
- in_active  in  $clog2(NUM_PES)+1  active elements in this beat, 1..NUM_PES
- vs1_data, vs2_data, vs3_data  in  DW  lane operands, lane i = bits [32i+31:32i]
- scalar_operand  in  32  x-register operand
- imm_operand  in  5  instruction immediate
- unsigned_immediate  in  1  zero-extend (1) or sign-extend (0) the immediate
- op / saturate_mode / output_mode / operand_select  in  package enums  PE controls, forwarded to all lanes
- widening, mul_us, vsew  in  2 each  forwarded to all lanes
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  DW  result beat
- out_last  out  1  copy of in_last of the producing beat
- replicated_scalar  out  DW  combinational scalar/immediate replicated at vsew (used for vmv.v.x / vmv.v.i)

Behaviour:
- Reset values (clocked while reset=1): out_valid=0, out_data=0, out_last=0, accumulator=0, state=IDLE. in_ready is 0 during reset.
- Accept condition: a beat is accepted when in_valid & in_ready.
- in_ready = ~out_valid | out_ready. This is a combinational path from out_ready when the skid feature is off.
- Elementwise mode (operand_select != PE_OPERAND_RIPPLE):
  - Each accepted beat produces exactly one output beat.
  - Latency: 1 cycle; the result is registered into out_data on the accept edge.
  - Lanes at index ≥ in_active output 0.
- Operand select, per lane:
  - PE_OPERAND_VS1: b = vs1 lane.
  - PE_OPERAND_SCALAR: b = replicated_scalar lane.
  - PE_OPERAND_IMMEDIATE: b = imm extended per unsigned_immediate; the replicator is fed the sign-extended immediate.
- Reduction mode (operand_select == PE_OPERAND_RIPPLE):
  - FSM states: IDLE, RED_ACC.
  - IDLE → RED_ACC on an accepted ripple beat with in_last=0.
  - RED_ACC → IDLE on an accepted beat with in_last=1.
  - An accepted ripple beat with in_last=1 in IDLE (single-beat reduction) stays in IDLE.
  - Lane 0 b-input: vs1 lane 0 when state=IDLE, otherwise the accumulator.
  - Lane i>0 b-input: output of lane i-1.
  - The chain result is the output of lane in_active-1.
  - Non-last beat: the chain result is written to the accumulator; no output beat is produced.
  - Last beat: out_data = {0, chain result} (element 0 only); out_valid=1; accumulator cleared to 0.
- Simultaneous events: out_valid & out_ready with a new accept in the same cycle loads the new result with no bubble.
- Back-pressure: out_valid=1 & out_ready=0 holds out_data, out_last and the accumulator stable, and drops in_ready.
- Reset asserted mid-reduction aborts the reduction: state=IDLE, accumulator=0, any pending output is discarded.
- An elementwise beat arriving while state=RED_ACC is a protocol error. It is processed elementwise; state and accumulator are unchanged.
- in_active=0 is illegal and is treated as NUM_PES.

Optional Feature:
- Macro: ARITH_STAGE_PIPE_SKID_EN.
- Defined: adds a 2-entry skid buffer on the output.
  - in_ready = ~skid_full, a registered signal.
  - Full throughput is sustained.
  - On a stall, up to 2 results are held; order is preserved.
- Undefined: single output register, with in_ready as specified in Behaviour.

Decomposition:
- accelerator_pkg gains:
  - arith_pipe_state_t {IDLE, RED_ACC}.
  - Constant PE_WIDTH = 32.
- pe_arith_op_t, pe_operand_t, pe_saturate_mode_t and pe_output_mode_t are reused from the package.
- Existing pe_32b is instantiated with a generate loop; scalar_replicate drives lane 0, and its 32-bit result is copied to all lanes.
- One new sub-module: arith_out_buf (output register/skid, valid/ready), reusable by other stages.

Test Plan:
- Add, NUM_PES=4, vsew=32, vs2 lanes={1,2,3,4}, vs1 lanes={10,20,30,40}, VS1 select, out_ready=1 → next cycle out_valid=1, out_data lanes={11,22,33,44}, out_last copied.
- Reduction sum over 3 beats (in_active=4,4,2), vs2 = 1..10, vs1[0]=100 → only the third beat produces output; element 0 = 155, other lanes 0; state returns to IDLE.
- out_ready held 0 for 3 cycles after a valid output → out_data stable, in_ready=0 (skid off), no beat lost; release → next beat accepted the same cycle.
- Immediate 5'b11111 signed, vsew=8 → replicated_scalar = all 0xFF; unsigned_immediate=1 with add → b = 31 per lane.
- Reset asserted after the first reduction beat → a fresh 1-beat reduction of {5,5,5,5}, vs1[0]=0 → result 20 (no stale accumulator).
- Skid on: out_ready toggling 1,0,1,0 under continuous in_valid → no drops, in-order outputs, in_ready falls only when 2 results are held.

Source files
------------

// File: rtl/arith_stage_pipe_pkg.sv
// Shared types and constants for the PE arithmetic stage pipeline.
package arith_stage_pipe_pkg;

  localparam int unsigned PE_WIDTH = 32;

  typedef enum logic [2:0] {
    PE_ADD, PE_SUB, PE_MUL, PE_AND, PE_OR, PE_XOR, PE_MIN, PE_MAX
  } pe_arith_op_t;

  typedef enum logic [1:0] {
    PE_OPERAND_VS1, PE_OPERAND_SCALAR, PE_OPERAND_IMMEDIATE, PE_OPERAND_RIPPLE
  } pe_operand_t;

  typedef enum logic [1:0] {
    PE_SAT_NONE, PE_SAT_SIGNED, PE_SAT_UNSIGNED
  } pe_saturate_mode_t;

  typedef enum logic {
    PE_OUT_NORMAL, PE_OUT_MACC
  } pe_output_mode_t;

  typedef enum logic {
    IDLE, RED_ACC
  } arith_pipe_state_t;

  // 5-bit instruction immediate widened to one PE element
  function automatic logic [PE_WIDTH-1:0] imm_extend(input logic [4:0] imm, input logic zero_ext);
    return zero_ext ? {27'b0, imm} : {{27{imm[4]}}, imm};
  endfunction

endpackage

// File: rtl/arith_stage_pipe_if.sv
// Operand-fetch -> arith stage -> writeback stream bundle.
interface arith_stage_pipe_if import arith_stage_pipe_pkg::*; #(
  parameter int unsigned NUM_PES = 4
) ();
  localparam int unsigned DW = PE_WIDTH * NUM_PES;
  localparam int unsigned AW = $clog2(NUM_PES) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [AW-1:0]         in_active;
  logic [DW-1:0]         vs1_data;
  logic [DW-1:0]         vs2_data;
  logic [DW-1:0]         vs3_data;
  logic [PE_WIDTH-1:0]   scalar_operand;
  logic [4:0]            imm_operand;
  logic                  unsigned_immediate;
  pe_arith_op_t          op;
  pe_saturate_mode_t     saturate_mode;
  pe_output_mode_t       output_mode;
  pe_operand_t           operand_select;
  logic [1:0]            widening;
  logic [1:0]            mul_us;
  logic [1:0]            vsew;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic                  out_last;
  logic [DW-1:0]         replicated_scalar;

  modport slave (
    input  in_valid, in_last, in_active, vs1_data, vs2_data, vs3_data,
           scalar_operand, imm_operand, unsigned_immediate, op, saturate_mode,
           output_mode, operand_select, widening, mul_us, vsew, out_ready,
    output in_ready, out_valid, out_data, out_last, replicated_scalar
  );

  modport master (
    output in_valid, in_last, in_active, vs1_data, vs2_data, vs3_data,
           scalar_operand, imm_operand, unsigned_immediate, op, saturate_mode,
           output_mode, operand_select, widening, mul_us, vsew, out_ready,
    input  in_ready, out_valid, out_data, out_last, replicated_scalar
  );
endinterface

// File: rtl/arith_out_buf.sv
// Registered valid/ready output stage. Define ARITH_STAGE_PIPE_SKID_EN for a 2-entry skid
// buffer with registered in_ready; otherwise a single register with combinational in_ready.
module arith_out_buf #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
`ifdef ARITH_STAGE_PIPE_SKID_EN
  logic         skid_full;
  logic [W-1:0] skid_data;

  assign in_ready = ~skid_full & ~reset;

  // out_data is the head entry, skid_data the second; order is head first
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (skid_full) begin
      if (out_ready) begin
        out_data  <= skid_data;
        skid_full <= 1'b0;
      end
    end else if (out_valid) begin
      if (out_ready) begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end else if (in_valid) begin
        skid_data <= in_data;
        skid_full <= 1'b1;
      end
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end
  end
`else
  assign in_ready = ~reset & (~out_valid | out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
`endif
endmodule

// File: rtl/pe_32b.sv
// Single 32-bit PE lane: add/sub with optional saturation, mul, logic, min/max, optional c accumulate.
module pe_32b import arith_stage_pipe_pkg::*; (
  input  pe_arith_op_t        op,
  input  pe_saturate_mode_t   saturate_mode,
  input  pe_output_mode_t     output_mode,
  input  logic [1:0]          widening,
  input  logic [1:0]          mul_us,
  input  logic [PE_WIDTH-1:0] a,
  input  logic [PE_WIDTH-1:0] b,
  input  logic [PE_WIDTH-1:0] c,
  output logic [PE_WIDTH-1:0] result
);
  logic [PE_WIDTH:0]     sum;
  logic [PE_WIDTH:0]     diff;
  logic [2*PE_WIDTH-1:0] a_ext;
  logic [2*PE_WIDTH-1:0] b_ext;
  logic [2*PE_WIDTH-1:0] prod;
  logic [PE_WIDTH-1:0]   base;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    // low 64 product bits are signedness-independent once operands are extended
    a_ext = mul_us[1] ? {32'b0, a} : {{32{a[31]}}, a};
    b_ext = mul_us[0] ? {32'b0, b} : {{32{b[31]}}, b};
    prod  = a_ext * b_ext;
    base  = '0;
    case (op)
      PE_ADD: begin
        base = sum[PE_WIDTH-1:0];
        if (saturate_mode == PE_SAT_UNSIGNED && sum[PE_WIDTH]) base = '1;
        else if (saturate_mode == PE_SAT_SIGNED && a[31] == b[31] && sum[31] != a[31])
          base = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      PE_SUB: begin
        base = diff[PE_WIDTH-1:0];
        if (saturate_mode == PE_SAT_UNSIGNED && diff[PE_WIDTH]) base = '0;
        else if (saturate_mode == PE_SAT_SIGNED && a[31] != b[31] && diff[31] != a[31])
          base = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      PE_MUL:  base = (widening != 2'b00) ? prod[2*PE_WIDTH-1:PE_WIDTH] : prod[PE_WIDTH-1:0];
      PE_AND:  base = a & b;
      PE_OR:   base = a | b;
      PE_XOR:  base = a ^ b;
      PE_MIN:  base = ($signed(a) < $signed(b)) ? a : b;
      PE_MAX:  base = ($signed(a) < $signed(b)) ? b : a;
      default: base = '0;
    endcase
    result = (output_mode == PE_OUT_MACC) ? base + c : base;
  end
endmodule

// File: rtl/scalar_replicate.sv
// Replicates the low element of a 32-bit value across the word at the given element width.
module scalar_replicate (
  input  logic [31:0] value,
  input  logic [1:0]  vsew,
  output logic [31:0] result
);
  always_comb begin
    case (vsew)
      2'd0:    result = {4{value[7:0]}};
      2'd1:    result = {2{value[15:0]}};
      default: result = value;
    endcase
  end
endmodule

// File: rtl/arith_stage_pipe.sv
// PE arithmetic stage: NUM_PES lanes, operand select, multi-beat ripple reduction, registered
// valid/ready output (skid buffer when ARITH_STAGE_PIPE_SKID_EN is defined).
module arith_stage_pipe import arith_stage_pipe_pkg::*; #(
  parameter int unsigned NUM_PES = 4
) (
  input logic              clk,
  input logic              reset,
  arith_stage_pipe_if.slave bus
);
  localparam int unsigned DW = PE_WIDTH * NUM_PES;
  localparam int unsigned AW = $clog2(NUM_PES) + 1;
  localparam int unsigned LW = $clog2(NUM_PES);

  arith_pipe_state_t   state, state_nxt;
  logic [PE_WIDTH-1:0] acc, acc_nxt;
  logic [PE_WIDTH-1:0] imm_sext, imm_ext, rep_src, rep_lane, chain;
  logic [PE_WIDTH-1:0] lane_res [NUM_PES];
  logic [AW-1:0]       active_eff;
  logic [LW-1:0]       last_idx;
  logic [DW-1:0]       ew_data, result;
  logic [DW:0]         buf_q;
  logic                ripple, accept, push, buf_ready;

  assign imm_sext = imm_extend(bus.imm_operand, 1'b0);
  assign imm_ext  = imm_extend(bus.imm_operand, bus.unsigned_immediate);
  assign rep_src  = (bus.operand_select == PE_OPERAND_IMMEDIATE) ? imm_sext : bus.scalar_operand;

  scalar_replicate u_rep (.value(rep_src), .vsew(bus.vsew), .result(rep_lane));
  assign bus.replicated_scalar = {NUM_PES{rep_lane}};

  // in_active == 0 is illegal and means a full beat
  assign active_eff = (bus.in_active == '0) ? AW'(NUM_PES) : bus.in_active;
  assign last_idx   = LW'(active_eff - AW'(1));
  assign ripple     = (bus.operand_select == PE_OPERAND_RIPPLE);

  for (genvar i = 0; i < NUM_PES; i++) begin : g_lane
    logic [PE_WIDTH-1:0] b, res, chain_in;

    if (i == 0) begin : g_head
      assign chain_in = (state == IDLE) ? bus.vs1_data[PE_WIDTH-1:0] : acc;
    end else begin : g_link
      assign chain_in = g_lane[i-1].res;
    end

    always_comb begin
      b = bus.vs1_data[i*PE_WIDTH +: PE_WIDTH];
      case (bus.operand_select)
        PE_OPERAND_SCALAR:    b = rep_lane;
        PE_OPERAND_IMMEDIATE: b = imm_ext;
        PE_OPERAND_RIPPLE:    b = chain_in;
        default:              ;
      endcase
    end

    pe_32b u_pe (
      .op            (bus.op),
      .saturate_mode (bus.saturate_mode),
      .output_mode   (bus.output_mode),
      .widening      (bus.widening),
      .mul_us        (bus.mul_us),
      .a             (bus.vs2_data[i*PE_WIDTH +: PE_WIDTH]),
      .b             (b),
      .c             (bus.vs3_data[i*PE_WIDTH +: PE_WIDTH]),
      .result        (res)
    );

    assign lane_res[i] = res;
    assign ew_data[i*PE_WIDTH +: PE_WIDTH] = (AW'(i) < active_eff) ? res : '0;
  end

  assign chain  = lane_res[last_idx];
  assign result = ripple ? {{(DW-PE_WIDTH){1'b0}}, chain} : ew_data;
  assign accept = bus.in_valid & buf_ready;
  assign push   = accept & (~ripple | bus.in_last);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // elementwise beats leave state and accumulator alone, even mid-reduction
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    if (accept && ripple) begin
      state_nxt = bus.in_last ? IDLE : RED_ACC;
      acc_nxt   = bus.in_last ? '0 : chain;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else       acc <= acc_nxt;
  end

  arith_out_buf #(.W(DW + 1)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (push),
    .in_ready  (buf_ready),
    .in_data   ({bus.in_last, result}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (buf_q)
  );

  assign bus.in_ready = buf_ready;
  assign bus.out_last = buf_q[DW];
  assign bus.out_data = buf_q[DW-1:0];
endmodule
